// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared constants and FSM state type for the UART packet loader
package uart_loader_pkg;

  localparam logic [7:0]  ACK_BYTE = 8'h06;
  localparam logic [7:0]  NAK_BYTE = 8'h15;
  localparam logic [15:0] CRC_POLY = 16'hA001;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [3:0] {
    IDLE,
    SEQ,
    DATA,
    CRC_LO,
    CRC_HI,
    CHECK,
    WRITE,
    REPLY,
    DONE
  } state_t;

endpackage

// File: rtl/crc16_modbus_byte.sv
// rtl/crc16_modbus_byte.sv - folds one byte into a CRC-16/Modbus remainder (reflected, LSB first)
module crc16_modbus_byte
  import uart_loader_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in ^ {8'h00, data_in};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/uart_pkt_loader.sv
// rtl/uart_pkt_loader.sv - framed UART packet loader: CRC/sequence check, ACK/NAK reply, ROM word writes
module uart_pkt_loader
  import uart_loader_pkg::*;
#(
  parameter int                PKT_BYTES      = 128,
  parameter int                SIZE_INDEX     = 60,
  parameter int                DATA_W         = 32,
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] ADDR_BASE      = '0,
  parameter int                TIMEOUT_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err_timeout
);

  localparam int B     = DATA_W / 8;
  localparam int IDX_W = $clog2(PKT_BYTES);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state;
  logic [7:0]        seq;
  logic [7:0]        exp_seq;
  logic [7:0]        seq_inc;
  logic [31:0]       file_size;
  logic [31:0]       wr_ptr;
  logic [31:0]       next_ptr;
  logic [15:0]       crc;
  logic [15:0]       crc_next;
  logic [15:0]       rx_crc;
  logic [IDX_W-1:0]  byte_cnt;
  logic [IDX_W-1:0]  woff;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              rx_phase;
  logic              tmo_hit;
  logic [7:0]        buffer [PKT_BYTES];
  logic [DATA_W-1:0] word;

  crc16_modbus_byte u_crc (
    .crc_in  (crc),
    .data_in (rx_data),
    .crc_out (crc_next)
  );

  always_comb begin
    word = '0;
    for (int i = 0; i < B; i++) begin
      word[8*i +: 8] = buffer[woff + IDX_W'(i)];
    end
  end

  assign next_ptr  = wr_ptr + 32'(B);
  // Sequence 0 is reserved for the size packet, so the counter skips it on wrap.
  assign seq_inc   = (exp_seq == 8'hFF) ? 8'h01 : exp_seq + 8'h01;
  assign rx_phase  = (state == DATA) || (state == CRC_LO) || (state == CRC_HI);
  assign tmo_hit   = rx_phase && !rx_valid && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign mem_addr  = ADDR_BASE + ADDR_W'(wr_ptr);
  assign mem_wdata = mem_req ? word : '0;
  assign busy      = (state == DATA) || (state == CRC_LO) || (state == CRC_HI) ||
                     (state == CHECK) || (state == WRITE) || (state == REPLY);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst || !rx_phase || rx_valid) tmo_cnt <= '0;
    else                              tmo_cnt <= tmo_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst && en && state == DATA && rx_valid) buffer[byte_cnt] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      seq         <= '0;
      exp_seq     <= '0;
      file_size   <= '0;
      wr_ptr      <= '0;
      crc         <= CRC_INIT;
      rx_crc      <= '0;
      byte_cnt    <= '0;
      woff        <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      mem_req     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      if (!en) begin
        tx_valid <= 1'b0;
        // A write already presented to memory must complete before we abandon the load.
        if (!(mem_req && !mem_ack)) begin
          state     <= IDLE;
          mem_req   <= 1'b0;
          exp_seq   <= '0;
          wr_ptr    <= '0;
          file_size <= '0;
        end
      end else if (tmo_hit) begin
        err_timeout <= 1'b1;
        state       <= SEQ;
      end else begin
        case (state)
          IDLE: state <= SEQ;
          SEQ: if (rx_valid) begin
            seq      <= rx_data;
            crc      <= CRC_INIT;
            byte_cnt <= '0;
            state    <= DATA;
          end
          DATA: if (rx_valid) begin
            crc      <= crc_next;
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == IDX_W'(PKT_BYTES - 1)) state <= CRC_LO;
          end
          CRC_LO: if (rx_valid) begin
            rx_crc[7:0] <= rx_data;
            state       <= CRC_HI;
          end
          CRC_HI: if (rx_valid) begin
            rx_crc[15:8] <= rx_data;
            state        <= CHECK;
          end
          CHECK: begin
            tx_valid <= 1'b1;
            state    <= REPLY;
            if (crc != rx_crc) begin
              tx_data <= NAK_BYTE;
            end else if (seq == 8'h00 && exp_seq == 8'h00) begin
              file_size <= {buffer[IDX_W'(SIZE_INDEX)],     buffer[IDX_W'(SIZE_INDEX + 1)],
                            buffer[IDX_W'(SIZE_INDEX + 2)], buffer[IDX_W'(SIZE_INDEX + 3)]};
              exp_seq   <= 8'h01;
              tx_data   <= ACK_BYTE;
            end else if (seq == exp_seq && exp_seq != 8'h00) begin
              tx_valid <= 1'b0;
              woff     <= '0;
              mem_req  <= 1'b1;
              state    <= WRITE;
            end else if (exp_seq != 8'h00 && seq == exp_seq - 8'd1) begin
              tx_data <= ACK_BYTE;
            end else begin
              tx_data <= NAK_BYTE;
            end
          end
          WRITE: if (mem_ack) begin
            wr_ptr <= next_ptr;
            woff   <= woff + IDX_W'(B);
            if (woff == IDX_W'(PKT_BYTES - B) || next_ptr >= file_size) begin
              mem_req  <= 1'b0;
              exp_seq  <= seq_inc;
              tx_data  <= ACK_BYTE;
              tx_valid <= 1'b1;
              state    <= REPLY;
            end
          end
          REPLY: if (tx_ready) begin
            tx_valid <= 1'b0;
            // An empty file is complete as soon as the size packet is accepted.
            state    <= (exp_seq != 8'h00 && wr_ptr >= file_size) ? DONE : SEQ;
          end
          DONE:    state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
